wb_data_arbiter: RTL and testbench

Two-master Wishbone (pipelined) arbiter that shares one data-memory slave port between the core's data interface (master 0) and a second bus master such as a DMA or debug module (master 1). It sits between the core wrapper's data Wishbone port and the data memory / peripheral interconnect. It grants the bus round-robin for whole Wishbone cycles, tracks outstanding transactions, and masks stall/ack/err toward the non-granted master.

---
 rtl/wb_data_arbiter_pkg.sv | 27 ++
 rtl/wb_data_arbiter_if.sv | 27 ++
 rtl/wb_data_arbiter_out_counter.sv | 42 ++++
 rtl/wb_data_arbiter.sv | 119 +++++++++++
 tb/tb_wb_data_arbiter.sv | 147 ++++++++++++++
 5 files changed

// File: rtl/wb_data_arbiter_pkg.sv
// Shared types and constants for the two-master Wishbone data arbiter.
// Holds the arbiter state encoding, bus widths and the idle-state grant decision.
package wb_data_arbiter_pkg;

    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } arb_state_e;

    // last = 1 means master 1 held the bus most recently, so master 0 wins a tie.
    function automatic arb_state_e arb_pick(input logic cyc0, input logic cyc1, input logic last);
        if (cyc0 && cyc1) begin
            return last ? ST_GNT0 : ST_GNT1;
        end else if (cyc0) begin
            return ST_GNT0;
        end else if (cyc1) begin
            return ST_GNT1;
        end
        return ST_IDLE;
    endfunction

endpackage

// File: rtl/wb_data_arbiter_if.sv
// Pipelined Wishbone port bundle; the master modport drives cyc/stb/address/write data,
// the slave modport drives stall/ack/err/read data.
interface wb_data_arbiter_if;
    import wb_data_arbiter_pkg::*;

    logic                cyc;
    logic                stb;
    logic                we;
    logic [WB_ADR_W-1:0] adr;
    logic [WB_DAT_W-1:0] dat_w;
    logic [WB_SEL_W-1:0] sel;
    logic                stall;
    logic                ack;
    logic                err;
    logic [WB_DAT_W-1:0] dat_r;

    modport master (
        output cyc, stb, we, adr, dat_w, sel,
        input  stall, ack, err, dat_r
    );

    modport slave (
        input  cyc, stb, we, adr, dat_w, sel,
        output stall, ack, err, dat_r
    );

endinterface

// File: rtl/wb_data_arbiter_out_counter.sv
// Outstanding-transfer counter for the granted cycle: counts accepted strobes
// that have not yet seen ack/err, with full/empty flags.
module wb_out_counter #(
    parameter  int MAX_OUT = 4,
    localparam int CNT_W   = $clog2(MAX_OUT + 1)
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic inc_i,
    input  logic dec_i,
    output logic full_o,
    output logic empty_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Simultaneous accept and response leave the count unchanged; responses at zero are strays.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i && !dec_i && !full_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (dec_i && !inc_i && !empty_o) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign full_o  = (cnt_q == CNT_W'(MAX_OUT));
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/wb_data_arbiter.sv
// Two-master pipelined Wishbone arbiter: round-robin grant per whole cycle, outstanding
// transfer limit, and stall/ack/err masking toward the master that does not own the bus.
module wb_data_arbiter
    import wb_data_arbiter_pkg::*;
#(
    parameter int MAX_OUT = 4
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    wb_data_arbiter_if.slave     m0_if,
    wb_data_arbiter_if.slave     m1_if,
    wb_data_arbiter_if.master    s_if
);

    arb_state_e state_q;
    logic       last_q;

    logic gnt0;
    logic gnt1;
    logic full;
    logic empty;
    logic accept;
    logic done;
    logic fwd_ok;
    logic release_gnt;

    assign gnt0 = (state_q == ST_GNT0);
    assign gnt1 = (state_q == ST_GNT1);

    // Grant is held for the whole cyc; dropping cyc costs one IDLE cycle before re-arbitration.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q <= arb_pick(m0_if.cyc, m1_if.cyc, last_q);
                end
                ST_GNT0: begin
                    if (!m0_if.cyc) begin
                        state_q <= ST_IDLE;
                        last_q  <= 1'b0;
                    end
                end
                ST_GNT1: begin
                    if (!m1_if.cyc) begin
                        state_q <= ST_IDLE;
                        last_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        s_if.cyc   = 1'b0;
        s_if.stb   = 1'b0;
        s_if.we    = 1'b0;
        s_if.adr   = m0_if.adr;
        s_if.dat_w = m0_if.dat_w;
        s_if.sel   = m0_if.sel;
        if (gnt0) begin
            s_if.cyc = m0_if.cyc;
            s_if.stb = m0_if.stb & ~full;
            s_if.we  = m0_if.we;
        end else if (gnt1) begin
            s_if.cyc   = m1_if.cyc;
            s_if.stb   = m1_if.stb & ~full;
            s_if.we    = m1_if.we;
            s_if.adr   = m1_if.adr;
            s_if.dat_w = m1_if.dat_w;
            s_if.sel   = m1_if.sel;
        end
    end

    assign accept      = s_if.stb & ~s_if.stall;
    assign done        = s_if.ack | s_if.err;
    assign fwd_ok      = ~empty | accept;
    assign release_gnt = (gnt0 & ~m0_if.cyc) | (gnt1 & ~m1_if.cyc);

    // Releasing the bus discards whatever responses the old owner left in flight.
    wb_out_counter #(
        .MAX_OUT (MAX_OUT)
    ) u_out_counter (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (release_gnt | (state_q == ST_IDLE)),
        .inc_i   (accept),
        .dec_i   (done),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        m0_if.stall = 1'b1;
        m0_if.ack   = 1'b0;
        m0_if.err   = 1'b0;
        m1_if.stall = 1'b1;
        m1_if.ack   = 1'b0;
        m1_if.err   = 1'b0;
        if (gnt0) begin
            m0_if.stall = s_if.stall | full;
            m0_if.ack   = s_if.ack & fwd_ok;
            m0_if.err   = s_if.err & fwd_ok;
        end else if (gnt1) begin
            m1_if.stall = s_if.stall | full;
            m1_if.ack   = s_if.ack & fwd_ok;
            m1_if.err   = s_if.err & fwd_ok;
        end
    end

    assign m0_if.dat_r = s_if.dat_r;
    assign m1_if.dat_r = s_if.dat_r;

endmodule

// File: tb/tb_wb_data_arbiter.sv
// Directed bench for wb_data_arbiter: one vector per clock, each with hand-computed
// expected {s_cyc, s_stb, m0_stall, m1_stall, m0_ack, m0_err, m1_ack, m1_err}.
module tb_wb_data_arbiter;

    logic clk_i   = 1'b0;
    logic reset_i = 1'b0;

    int checkCount = 0;
    int errorCount = 0;

    wb_data_arbiter_if m0_if ();
    wb_data_arbiter_if m1_if ();
    wb_data_arbiter_if s_if ();

    wb_data_arbiter #(
        .MAX_OUT (4)
    ) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .m0_if   (m0_if),
        .m1_if   (m1_if),
        .s_if    (s_if)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // stim = {reset_i, m0_cyc, m0_stb, m1_cyc, m1_stb, s_stall, s_ack, s_err}
    task automatic applyStimulus(input string tag, input logic [7:0] stim, input logic [7:0] expv);
        logic [7:0] obs;
        @(posedge clk_i);
        #1;
        reset_i     = stim[7];
        m0_if.cyc   = stim[6];
        m0_if.stb   = stim[5];
        m1_if.cyc   = stim[4];
        m1_if.stb   = stim[3];
        s_if.stall  = stim[2];
        s_if.ack    = stim[1];
        s_if.err    = stim[0];
        #1;
        obs = {s_if.cyc, s_if.stb, m0_if.stall, m1_if.stall,
               m0_if.ack, m0_if.err, m1_if.ack, m1_if.err};
        checkOutput(tag, {24'd0, obs}, {24'd0, expv});
    endtask

    initial begin
        m0_if.cyc = 1'b0; m0_if.stb = 1'b0; m0_if.we = 1'b0;
        m0_if.adr = 32'h0; m0_if.dat_w = 32'h1111_0000; m0_if.sel = 4'hF;
        m1_if.cyc = 1'b0; m1_if.stb = 1'b0; m1_if.we = 1'b0;
        m1_if.adr = 32'h0; m1_if.dat_w = 32'h2222_0000; m1_if.sel = 4'h3;
        s_if.stall = 1'b0; s_if.ack = 1'b0; s_if.err = 1'b0; s_if.dat_r = 32'h0;

        // Reset held with both masters requesting, then master 0 wins the first tie.
        applyStimulus("rst0", 8'b0_10_10_0_00, 8'b0011_0000);
        applyStimulus("rst1", 8'b0_10_10_0_00, 8'b0011_0000);
        applyStimulus("rst2", 8'b0_10_10_0_00, 8'b0011_0000);
        applyStimulus("rstRelease", 8'b1_10_10_0_00, 8'b0011_0000);
        applyStimulus("firstGnt0", 8'b1_10_10_0_00, 8'b1001_0000);
        applyStimulus("bothDrop", 8'b1_00_00_0_00, 8'b0001_0000);

        // Single read by master 0, ack two cycles after accept.
        m0_if.adr = 32'h0000_0100;
        s_if.dat_r = 32'hDEAD_BEEF;
        applyStimulus("singleIdle", 8'b1_11_00_0_00, 8'b0011_0000);
        applyStimulus("singleStb", 8'b1_11_00_0_00, 8'b1101_0000);
        checkOutput("singleAdr", s_if.adr, 32'h0000_0100);
        checkOutput("singleSel", {28'd0, s_if.sel}, 32'h0000_000F);
        applyStimulus("singleWait", 8'b1_10_00_0_00, 8'b1001_0000);
        applyStimulus("singleAck", 8'b1_10_00_0_10, 8'b1001_1000);
        checkOutput("singleDat", m0_if.dat_r, 32'hDEAD_BEEF);
        applyStimulus("singleAfter", 8'b1_10_00_0_00, 8'b1001_0000);
        applyStimulus("singleDrop", 8'b1_00_00_0_00, 8'b0001_0000);
        applyStimulus("idleStray", 8'b1_00_00_0_10, 8'b0011_0000);

        // Contention from a fresh reset so master 0 is favoured.
        applyStimulus("rstAgain", 8'b0_00_00_0_00, 8'b0011_0000);
        m0_if.adr = 32'h0000_0200;
        m1_if.adr = 32'h0000_0300;
        applyStimulus("contIdle", 8'b1_11_11_0_00, 8'b0011_0000);
        applyStimulus("contGnt0", 8'b1_11_11_0_00, 8'b1101_0000);
        checkOutput("contAdr0", s_if.adr, 32'h0000_0200);
        applyStimulus("contWait0", 8'b1_10_11_0_00, 8'b1001_0000);
        applyStimulus("contAck0", 8'b1_10_11_0_10, 8'b1001_1000);
        applyStimulus("contDrop0", 8'b1_00_11_0_00, 8'b0001_0000);
        applyStimulus("contRearb", 8'b1_11_11_0_00, 8'b0011_0000);
        applyStimulus("contGnt1", 8'b1_11_11_0_00, 8'b1110_0000);
        checkOutput("contAdr1", s_if.adr, 32'h0000_0300);
        checkOutput("contDat1", s_if.dat_w, 32'h2222_0000);
        applyStimulus("contWait1", 8'b1_11_10_0_00, 8'b1010_0000);
        applyStimulus("contAck1", 8'b1_11_10_0_10, 8'b1010_0010);
        applyStimulus("contDrop1", 8'b1_11_00_0_00, 8'b0010_0000);
        applyStimulus("contRearb2", 8'b1_11_00_0_00, 8'b0011_0000);
        applyStimulus("contGnt0b", 8'b1_11_00_0_00, 8'b1101_0000);
        applyStimulus("contDrop0b", 8'b1_00_00_0_00, 8'b0001_0000);

        // Six strobes against a limit of four, responses arriving five cycles after accept.
        m0_if.adr = 32'h0000_0400;
        applyStimulus("outIdle", 8'b1_11_00_0_00, 8'b0011_0000);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus($sformatf("outAcc%0d", i), 8'b1_11_00_0_00, 8'b1101_0000);
        end
        applyStimulus("outFull", 8'b1_11_00_0_00, 8'b1011_0000);
        applyStimulus("outFullAck", 8'b1_11_00_0_10, 8'b1011_1000);
        applyStimulus("outAccAck5", 8'b1_11_00_0_10, 8'b1101_1000);
        applyStimulus("outAccAck6", 8'b1_11_00_0_10, 8'b1101_1000);
        applyStimulus("outAck4", 8'b1_10_00_0_10, 8'b1001_1000);
        applyStimulus("outGap1", 8'b1_10_00_0_00, 8'b1001_0000);
        applyStimulus("outGap2", 8'b1_10_00_0_00, 8'b1001_0000);
        applyStimulus("outAck5", 8'b1_10_00_0_10, 8'b1001_1000);
        applyStimulus("outAck6", 8'b1_10_00_0_10, 8'b1001_1000);
        applyStimulus("outStray", 8'b1_10_00_0_10, 8'b1001_0000);

        // Slave stall, then an error on the second of two writes; grant survives the error.
        applyStimulus("errStall", 8'b1_11_00_1_00, 8'b1111_0000);
        m0_if.we = 1'b1;
        applyStimulus("errAcc1", 8'b1_11_00_0_00, 8'b1101_0000);
        checkOutput("errWe", {31'd0, s_if.we}, 32'h0000_0001);
        m0_if.we = 1'b0;
        applyStimulus("errAcc2", 8'b1_11_00_0_00, 8'b1101_0000);
        applyStimulus("errAck1", 8'b1_10_00_0_10, 8'b1001_1000);
        applyStimulus("errErr2", 8'b1_10_00_0_01, 8'b1001_0100);
        applyStimulus("errHeld", 8'b1_10_00_0_00, 8'b1001_0000);
        applyStimulus("errStray", 8'b1_10_00_0_01, 8'b1001_0000);
        applyStimulus("errDrop", 8'b1_00_00_0_00, 8'b0001_0000);

        // Master 1 abandons two transfers; late acks must not reach master 0.
        applyStimulus("abIdle", 8'b1_00_11_0_00, 8'b0011_0000);
        applyStimulus("abAcc1", 8'b1_00_11_0_00, 8'b1110_0000);
        applyStimulus("abAcc2", 8'b1_00_11_0_00, 8'b1110_0000);
        applyStimulus("abDrop", 8'b1_11_00_0_00, 8'b0010_0000);
        applyStimulus("abLateIdle", 8'b1_11_00_0_10, 8'b0011_0000);
        applyStimulus("abLateGnt0", 8'b1_10_00_0_10, 8'b1001_0000);
        applyStimulus("abEnd", 8'b1_00_00_0_00, 8'b0001_0000);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
